clk_div_multi: RTL

Parametrised multi-channel clock divider / tick generator; successor to the single-channel fixed-ratio divider. Each of N_CH channels divides the system clock by a runtime-programmable ratio. A channel produces either a 50 % square wave (toggle mode) or a one-cycle strobe (pulse mode), plus a per-channel tick. It feeds the motor-step, display-scan and debounce timing in the cube controller, replacing per-use fixed dividers.

---
 rtl/clk_div_multi.sv | 105 ++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock dividers / tick generators.
// Each channel owns a programmable divisor and a down-counter. At terminal
// count it emits a one-cycle tick and either toggles clkout (toggle mode)
// or strobes it high for one cycle (pulse mode). All outputs are registered.
module clk_div_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 1000000
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [N_CH-1:0]                      en_i,
    input  logic [N_CH-1:0]                      mode_i,
    input  logic                                 sync_i,
    input  logic                                 wr_en_i,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch_i,
    input  logic [CNT_W-1:0]                     wr_div_i,
    output logic [N_CH-1:0]                      clkout_o,
    output logic [N_CH-1:0]                      tick_o,
    output logic [N_CH-1:0]                      active_o
);

    localparam int             CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = '0;

    logic [CNT_W-1:0] div_q  [N_CH];
    logic [CNT_W-1:0] div_d  [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [CNT_W-1:0] reload [N_CH];
    logic [N_CH-1:0]  clkout_q, clkout_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  active_q;

    // Reload value D-1 from the divisor registered before this edge; a
    // divisor of 0 behaves as 1, so the counter never underflows.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            reload[c] = (div_q[c] == ZERO) ? ZERO : (div_q[c] - ONE);
        end
    end

    // Divisor write decode; channel indices at or beyond N_CH match nothing.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            div_d[c] = div_q[c];
            if (wr_en_i && (wr_ch_i == CH_W'(c))) begin
                div_d[c] = wr_div_i;
            end
        end
    end

    // Per-channel next state: disable > sync > terminal > decrement.
    always_comb begin
        clkout_d = clkout_q;
        tick_d   = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (!en_i[c]) begin
                cnt_d[c]    = reload[c];
                clkout_d[c] = 1'b0;
            end else if (sync_i) begin
                cnt_d[c]    = reload[c];
                clkout_d[c] = 1'b0;
            end else if (cnt_q[c] == ZERO) begin
                cnt_d[c]    = reload[c];
                tick_d[c]   = 1'b1;
                clkout_d[c] = mode_i[c] ? 1'b1 : ~clkout_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] - ONE;
                if (mode_i[c]) begin
                    clkout_d[c] = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < N_CH; c++) begin
                div_q[c] <= DEF_L;
                cnt_q[c] <= DEF_L - ONE;
            end
            clkout_q <= '0;
            tick_q   <= '0;
            active_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                div_q[c] <= div_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
            active_q <= en_i;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;
    assign active_o = active_q;

endmodule
